// File: rtl/tt_scan_pkg.sv
// Shared types and constants for the truth-table scan blocks.
package tt_scan_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } scan_state_t;

  localparam int N_VECT = 16;
  localparam int IDX_W  = 4;
  localparam int CNT_W  = 4;

  localparam logic [N_VECT-1:0] G_EXPECTED_DEF = 16'hF37A;
  localparam logic [N_VECT-1:0] H_EXPECTED_DEF = 16'h5E0B;

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module tt_settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         expired
);

  logic [W-1:0] cnt;

  // Load has priority; ticking stops at zero so the counter never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps all 16 {A,B,C,D} vectors into the function block, captures g/h
// after a settle time and compares the resulting truth tables to constants.
//
//  state   | meaning
//  IDLE    | stimulus 0000, waiting for start
//  DRIVE   | stimulus = idx, settling for SETTLE_CYCLES cycles
//  CAPTURE | stimulus held, g/h sampled into table bit idx at cycle end
//  DONE    | one-cycle done pulse, tables marked valid
module truth_table_scanner
  import tt_scan_pkg::*;
#(
  parameter int                SETTLE_CYCLES = 1,
  parameter logic [N_VECT-1:0] G_EXPECTED    = G_EXPECTED_DEF,
  parameter logic [N_VECT-1:0] H_EXPECTED    = H_EXPECTED_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              a_o,
  output logic              b_o,
  output logic              c_o,
  output logic              d_o,
  input  logic              g_in,
  input  logic              h_in,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic [N_VECT-1:0] g_table,
  output logic [N_VECT-1:0] h_table,
  output logic [N_VECT-1:0] g_mismatch,
  output logic [N_VECT-1:0] h_mismatch,
  output logic              pass
);

  // Timer is loaded with one less than the settle time because the
  // DRIVE cycle that sees the count at zero is itself a settle cycle.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_VECT - 1);

  scan_state_t      state;
  logic [IDX_W-1:0] idx;
  logic [3:0]       stim;
  logic             tmr_load;
  logic             tmr_tick;
  logic             tmr_expired;

  // Timer reload on every entry into DRIVE; it only counts while in DRIVE.
  always_comb begin
    tmr_load = 1'b0;
    tmr_tick = 1'b0;
    case (state)
      IDLE:    tmr_load = start & ~abort;
      DRIVE:   tmr_tick = 1'b1;
      CAPTURE: tmr_load = ~abort & (idx != IDX_LAST);
      default: ;
    endcase
  end

  tt_settle_timer #(
    .W (CNT_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (SETTLE_LOAD),
    .tick     (tmr_tick),
    .expired  (tmr_expired)
  );

  // Scan sequencer; all outputs except the mismatch/pass compare are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      stim    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      valid   <= 1'b0;
      g_table <= '0;
      h_table <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          stim <= '0;
          busy <= 1'b0;
          if (abort) begin
            valid <= 1'b0;
          end else if (start) begin
            state   <= DRIVE;
            idx     <= '0;
            stim    <= '0;
            busy    <= 1'b1;
            valid   <= 1'b0;
            g_table <= '0;
            h_table <= '0;
          end
        end
        DRIVE: begin
          if (abort) begin
            state <= IDLE;
            stim  <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
          end else if (tmr_expired) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          // Aborting here skips the capture; earlier bits stay for debug.
          if (abort) begin
            state <= IDLE;
            stim  <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
          end else begin
            g_table[idx] <= g_in;
            h_table[idx] <= h_in;
            if (idx == IDX_LAST) begin
              state <= DONE;
              stim  <= '0;
              done  <= 1'b1;
              valid <= 1'b1;
            end else begin
              state <= DRIVE;
              idx   <= idx + 1'b1;
              stim  <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          stim  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign {a_o, b_o, c_o, d_o} = stim;

  assign g_mismatch = g_table ^ G_EXPECTED;
  assign h_mismatch = h_table ^ H_EXPECTED;
  assign pass       = valid & ~|g_mismatch & ~|h_mismatch;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench: two scanners (settle 1 and settle 3) each driving a
// behavioural model of the function block.
module tb_truth_table_scanner;

  localparam logic [15:0] G_TBL = 16'hF37A;
  localparam logic [15:0] H_TBL = 16'h5E0B;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0, abort1 = 1'b0, start3 = 1'b0, abort3 = 1'b0;
  logic g_force0 = 1'b0, h_force1 = 1'b0;

  logic a1, b1, c1, d1, g_in1, h_in1, busy1, done1, valid1, pass1;
  logic [15:0] g_table1, h_table1, g_mm1, h_mm1;
  logic a3, b3, c3, d3, g_in3, h_in3, busy3, done3, valid3, pass3;
  logic [15:0] g_table3, h_table3, g_mm3, h_mm3;
  logic [3:0] stim1, stim3;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int k1, k3;

  typedef struct {
    int          s;
    int          dcyc;
    logic [15:0] g_tab;
    logic [15:0] h_tab;
    logic        pass;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign stim1 = {a1, b1, c1, d1};
  assign stim3 = {a3, b3, c3, d3};
  assign g_in1 = g_force0 ? 1'b0 : G_TBL[stim1];
  assign h_in1 = h_force1 ? 1'b1 : H_TBL[stim1];
  assign g_in3 = G_TBL[stim3];
  assign h_in3 = H_TBL[stim3];

  truth_table_scanner dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .a_o(a1), .b_o(b1), .c_o(c1), .d_o(d1), .g_in(g_in1), .h_in(h_in1),
    .busy(busy1), .done(done1), .valid(valid1), .g_table(g_table1),
    .h_table(h_table1), .g_mismatch(g_mm1), .h_mismatch(h_mm1), .pass(pass1)
  );

  truth_table_scanner #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
    .a_o(a3), .b_o(b3), .c_o(c3), .d_o(d3), .g_in(g_in3), .h_in(h_in3),
    .busy(busy3), .done(done3), .valid(valid3), .g_table(g_table3),
    .h_table(h_table3), .g_mismatch(g_mm3), .h_mismatch(h_mm3), .pass(pass3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    if (obs !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, req, cyc);
    end
  endtask

  // Expected result of a scan whose start is sampled in cycle s.
  task automatic push(input bit sel3, input int s);
    exp_t e;
    int settle;
    settle  = sel3 ? 3 : 1;
    e.s     = s;
    e.dcyc  = s + 1 + 16 * (settle + 1);
    e.g_tab = (!sel3 && g_force0) ? 16'h0000 : G_TBL;
    e.h_tab = (!sel3 && h_force1) ? 16'hFFFF : H_TBL;
    e.pass  = (e.g_tab == G_TBL) && (e.h_tab == H_TBL);
    if (sel3) q3.push_back(e);
    else      q1.push_back(e);
  endtask

  task automatic start_scan(input bit sel3);
    @(negedge clk);
    if (sel3) start3 = 1'b1;
    else      start1 = 1'b1;
    push(sel3, cyc);
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_drain(input bit sel3, input int budget);
    int n = 0;
    while (((sel3 ? q3.size() : q1.size()) > 0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    if (sel3) begin
      chk("drain_timeout3", q3.size(), 0);
      q3.delete();
    end else begin
      chk("drain_timeout1", q1.size(), 0);
      q1.delete();
    end
  endtask

  // Per-cycle stimulus/busy checks during a scan and result checks on done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (q1.size() > 0) begin
        k1 = cyc - q1[0].s;
        if (k1 >= 1 && k1 <= 32) begin
          chk("stim1", stim1, (k1 - 1) / 2);
          chk("busy1_scan", busy1, 1);
          chk("valid1_scan", valid1, 0);
        end
      end
      if (done1) begin
        if (q1.size() == 0) begin
          chk("unexpected_done1", done1, 0);
        end else begin
          e1 = q1.pop_front();
          chk("done_cycle1", cyc, e1.dcyc);
          chk("g_table1", g_table1, e1.g_tab);
          chk("h_table1", h_table1, e1.h_tab);
          chk("g_mismatch1", g_mm1, e1.g_tab ^ G_TBL);
          chk("h_mismatch1", h_mm1, e1.h_tab ^ H_TBL);
          chk("pass1", pass1, e1.pass);
          chk("valid1_done", valid1, 1);
          chk("busy1_done", busy1, 1);
          chk("stim1_done", stim1, 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (q3.size() > 0) begin
        k3 = cyc - q3[0].s;
        if (k3 >= 1 && k3 <= 64) begin
          chk("stim3", stim3, (k3 - 1) / 4);
          chk("busy3_scan", busy3, 1);
        end
      end
      if (done3) begin
        if (q3.size() == 0) begin
          chk("unexpected_done3", done3, 0);
        end else begin
          e3 = q3.pop_front();
          chk("done_cycle3", cyc, e3.dcyc);
          chk("g_table3", g_table3, e3.g_tab);
          chk("h_table3", h_table3, e3.h_tab);
          chk("pass3", pass3, e3.pass);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    repeat (3) @(negedge clk);
    chk("rst_stim", stim1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_valid", valid1, 0);
    chk("rst_g_table", g_table1, 0);
    chk("rst_h_table", h_table1, 0);
    chk("rst_pass", pass1, 0);
    rst_n = 1'b1;

    // golden scan against the model
    start_scan(1'b0);
    wait_drain(1'b0, 100);
    @(negedge clk);
    chk("valid_after_done", valid1, 1);
    chk("busy_after_done", busy1, 0);
    chk("pass_after_done", pass1, 1);

    // start pulse during a scan must not restart or add a scan
    start_scan(1'b0);
    repeat (10) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_drain(1'b0, 100);
    repeat (40) @(negedge clk);
    chk("no_restart_busy", busy1, 0);

    // stuck-at faults on the function outputs
    g_force0 = 1'b1;
    start_scan(1'b0);
    wait_drain(1'b0, 100);
    chk("g_fault_mismatch", g_mm1, 16'hF37A);
    chk("g_fault_h_clean", h_mm1, 16'h0000);
    g_force0 = 1'b0;
    h_force1 = 1'b1;
    start_scan(1'b0);
    wait_drain(1'b0, 100);
    chk("h_fault_mismatch", h_mm1, 16'hA1F4);
    chk("h_fault_pass", pass1, 0);
    h_force1 = 1'b0;

    // abort at scan cycle 10
    start_scan(1'b0);
    repeat (9) @(negedge clk);
    abort1 = 1'b1;
    q1.delete();
    @(negedge clk);
    abort1 = 1'b0;
    chk("abort_busy", busy1, 0);
    chk("abort_stim", stim1, 0);
    chk("abort_valid", valid1, 0);
    chk("abort_done", done1, 0);
    repeat (40) @(negedge clk);
    chk("abort_stays_idle", busy1, 0);

    // start and abort together in IDLE: abort wins
    @(negedge clk);
    start1 = 1'b1;
    abort1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    abort1 = 1'b0;
    chk("start_abort_busy", busy1, 0);
    repeat (3) @(negedge clk);
    chk("start_abort_idle", busy1, 0);

    // start held high: back-to-back scans every 34 cycles
    @(negedge clk);
    start1 = 1'b1;
    s = cyc;
    push(1'b0, s);
    push(1'b0, s + 34);
    push(1'b0, s + 68);
    repeat (69) @(negedge clk);
    start1 = 1'b0;
    wait_drain(1'b0, 200);
    repeat (5) @(negedge clk);
    chk("held_start_stops", busy1, 0);

    // settle of 3 cycles on the second instance
    start_scan(1'b1);
    wait_drain(1'b1, 200);
    @(negedge clk);
    chk("settle3_valid", valid3, 1);

    // asynchronous reset in the middle of a scan
    start_scan(1'b0);
    repeat (8) @(negedge clk);
    #2;
    rst_n = 1'b0;
    q1.delete();
    #1;
    chk("async_rst_stim", stim1, 0);
    chk("async_rst_busy", busy1, 0);
    chk("async_rst_done", done1, 0);
    chk("async_rst_valid", valid1, 0);
    chk("async_rst_g_table", g_table1, 0);
    chk("async_rst_h_table", h_table1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", busy1, 0);
    start_scan(1'b0);
    wait_drain(1'b0, 100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
